// File: rtl/axis_bram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// axis_bram_fifo_ctrl
//
// A single-clock AXI-Stream FIFO. It owns one fifo_mem block RAM with a
// registered read port, generates every address, write enable and full/empty
// flag, and hides the one-cycle read latency behind a two-entry
// first-word-fall-through output buffer (a head entry and a skid entry).
// Total capacity is MEM_DEPTH + 2 beats.
//
// Handshake: a beat moves on a rising edge of i_clk when valid and ready are
// both high in the cycle before that edge. A master holds valid and data
// steady until ready is seen. Ready never depends on valid.
//
// Optional feature macro: AXIS_FIFO_LEVEL_EN adds the registered o_level
// port, which reports the total number of beats held.
//
// Ports:
//   i_clk          single clock for the whole block
//   i_reset        synchronous, active-high reset
//   s_axis_tdata   write data
//   s_axis_tvalid  write request
//   s_axis_tready  controller can accept a beat (memory not full)
//   m_axis_tdata   head-of-FIFO data
//   m_axis_tvalid  head data valid
//   m_axis_tready  consumer accepts head
//   o_almost_full  registered, memory occupancy >= ALMOST_FULL_THRESH
//   o_level        registered total beat count (AXIS_FIFO_LEVEL_EN only)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// fifo_mem
//
// Simple dual-port block RAM. Writes are ignored while i_full is high, and
// reads are ignored while i_empty is high. With PIPELINE=1 the read data is
// registered and appears one cycle after the read request.
//
// Ports:
//   i_wr_clk, i_wr_en, i_full, i_wr_addr, i_wr_data   write port
//   i_rd_clk, i_rd_en, i_empty, i_rd_addr, o_rd_data  read port
// ---------------------------------------------------------------------------
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 6,
    parameter int PIPELINE   = 1
) (
    input  logic                  i_wr_clk,
    input  logic                  i_wr_en,
    input  logic                  i_full,
    input  logic [ADDR_BITS-1:0]  i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_clk,
    input  logic                  i_rd_en,
    input  logic                  i_empty,
    input  logic [ADDR_BITS-1:0]  i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge i_wr_clk) begin
        if (i_wr_en && !i_full) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    generate
        if (PIPELINE != 0) begin : g_reg_read
            always_ff @(posedge i_rd_clk) begin
                if (i_rd_en && !i_empty) begin
                    o_rd_data <= mem[i_rd_addr];
                end
            end
        end else begin : g_comb_read
            assign o_rd_data = mem[i_rd_addr];
        end
    endgenerate

endmodule

module axis_bram_fifo_ctrl #(
    parameter int DATA_WIDTH         = 8,
    parameter int MEM_DEPTH          = 64,
    parameter int ADDR_BITS          = $clog2(MEM_DEPTH),
    parameter int ALMOST_FULL_THRESH = MEM_DEPTH - 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  o_almost_full
`ifdef AXIS_FIFO_LEVEL_EN
    ,
    output logic [ADDR_BITS+1:0]  o_level
`endif
);

    localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(MEM_DEPTH);
    localparam logic [ADDR_BITS:0] AF_C    = (ADDR_BITS+1)'(ALMOST_FULL_THRESH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_BITS:0]    wr_ptr;
    logic [ADDR_BITS:0]    rd_ptr;
    logic [ADDR_BITS:0]    mem_count;
    logic [ADDR_BITS:0]    mem_count_next;
    logic                  mem_full;
    logic                  mem_empty;

    logic                  push;
    logic                  pop;
    logic                  fetch;
    logic                  inflight;

    // Output buffer: buf0 is the head, buf1 the skid entry.
    logic [DATA_WIDTH-1:0] buf0;
    logic [DATA_WIDTH-1:0] buf1;
    logic [1:0]            out_count;
    logic [1:0]            cnt_after_pop;
    logic [1:0]            out_count_next;
    logic [2:0]            committed;

    logic [DATA_WIDTH-1:0] rd_data;
    logic                  af_q;

    // ------------------------------------------------------------------
    // Occupancy and handshakes
    // ------------------------------------------------------------------
    assign mem_count = wr_ptr - rd_ptr;
    assign mem_full  = (mem_count == DEPTH_C);
    assign mem_empty = (mem_count == '0);

    assign s_axis_tready = !mem_full && !i_reset;
    assign m_axis_tvalid = (out_count != 2'd0) && !i_reset;
    assign m_axis_tdata  = i_reset ? '0 : buf0;
    assign o_almost_full = af_q && !i_reset;

    assign push = s_axis_tvalid && s_axis_tready;
    assign pop  = m_axis_tvalid && m_axis_tready;

    // Slots already spoken for in the output buffer once this cycle's pop
    // is taken into account. A fetch is only issued if a slot is left for
    // the word when it lands next cycle.
    assign committed = {1'b0, out_count} + {2'b00, inflight} - {2'b00, pop};
    assign fetch     = !mem_empty && (committed < 3'd2);

    assign cnt_after_pop  = out_count - {1'b0, pop};
    assign out_count_next = cnt_after_pop + {1'b0, inflight};

    assign mem_count_next = mem_count
                          + {{ADDR_BITS{1'b0}}, push}
                          - {{ADDR_BITS{1'b0}}, fetch};

    // ------------------------------------------------------------------
    // Block RAM. A fetch never reads the address being written in the same
    // cycle: that would need mem_count == 0, which blocks the fetch.
    // ------------------------------------------------------------------
    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS),
        .PIPELINE   (1)
    ) u_mem (
        .i_wr_clk  (i_clk),
        .i_wr_en   (push),
        .i_full    (mem_full),
        .i_wr_addr (wr_ptr[ADDR_BITS-1:0]),
        .i_wr_data (s_axis_tdata),
        .i_rd_clk  (i_clk),
        .i_rd_en   (fetch),
        .i_empty   (mem_empty),
        .i_rd_addr (rd_ptr[ADDR_BITS-1:0]),
        .o_rd_data (rd_data)
    );

    // ------------------------------------------------------------------
    // Pointers, read-in-flight flag, almost-full flag
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            af_q     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            inflight <= fetch;
            af_q     <= (mem_count_next >= AF_C);
        end
    end

    // ------------------------------------------------------------------
    // Output buffer. A pop shifts the skid entry into the head; a landing
    // word then goes into the first free entry that remains after the pop,
    // so a pop and a landing in the same cycle keep order. The landing
    // assignment comes last so it overrides the shift when both target buf0.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            buf0      <= '0;
            buf1      <= '0;
            out_count <= 2'd0;
        end else begin
            if (pop) begin
                buf0 <= buf1;
            end
            if (inflight) begin
                if (cnt_after_pop == 2'd0) begin
                    buf0 <= rd_data;
                end else begin
                    buf1 <= rd_data;
                end
            end
            out_count <= out_count_next;
        end
    end

`ifdef AXIS_FIFO_LEVEL_EN
    // ------------------------------------------------------------------
    // Total beats held after this edge: memory, in-flight word, buffer.
    // ------------------------------------------------------------------
    logic [ADDR_BITS+1:0] level_next;
    logic [ADDR_BITS+1:0] level_q;

    assign level_next = {1'b0, mem_count_next}
                      + {{(ADDR_BITS+1){1'b0}}, fetch}
                      + {{ADDR_BITS{1'b0}}, out_count_next};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            level_q <= '0;
        end else begin
            level_q <= level_next;
        end
    end

    assign o_level = i_reset ? '0 : level_q;
`endif

endmodule

// File: tb/tb_axis_bram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for axis_bram_fifo_ctrl (DATA_WIDTH=8, MEM_DEPTH=64).
// Inputs are driven on the falling edge and outputs are sampled 1 ns later,
// so a handshake seen at a sample completes on the following rising edge.
// The reference is a plain FIFO queue holding at most MEM_DEPTH+2 beats.
// ---------------------------------------------------------------------------
module tb_axis_bram_fifo_ctrl;

    localparam int DW   = 8;
    localparam int DEP  = 64;
    localparam int AB   = 6;
    localparam int CAP  = DEP + 2;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          o_almost_full;
`ifdef AXIS_FIFO_LEVEL_EN
    logic [AB+1:0] o_level;
`endif

    always #5 clk = ~clk;

    axis_bram_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (DEP)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .o_almost_full (o_almost_full)
`ifdef AXIS_FIFO_LEVEL_EN
        ,
        .o_level       (o_level)
`endif
    );

    // Scoreboard
    logic [DW-1:0] exp_q[$];
    int            total    = 0;
    int            passed   = 0;
    int            push_cnt = 0;
    int            pop_cnt  = 0;
    logic [DW-1:0] last_pop = '0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock of traffic: drive, sample, update the model.
    task automatic step(input logic sv, input logic [DW-1:0] sd, input logic mr);
        @(negedge clk);
        s_axis_tvalid = sv;
        s_axis_tdata  = sd;
        m_axis_tready = mr;
        #1;
        if (prev_stall) begin
            check("stable_valid", 32'(m_axis_tvalid), 32'd1);
            check("stable_data", 32'(m_axis_tdata), 32'(prev_data));
        end
        if (m_axis_tvalid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(m_axis_tvalid), 32'd0);
            end else begin
                check("head_data", 32'(m_axis_tdata), 32'(exp_q[0]));
                if (mr) begin
                    last_pop = exp_q.pop_front();
                    pop_cnt++;
                end
            end
        end
        if (sv && s_axis_tready) begin
            exp_q.push_back(sd);
            push_cnt++;
            check("overflow", 32'(exp_q.size() > CAP), 32'd0);
        end
        prev_stall = m_axis_tvalid && !mr;
        prev_data  = m_axis_tdata;
    endtask

    // One rising edge with reset high, then release.
    task automatic do_reset();
        @(negedge clk);
        i_reset       = 1'b1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        #1;
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_mdata", 32'(m_axis_tdata), 32'd0);
        check("rst_af", 32'(o_almost_full), 32'd0);
        @(negedge clk);
        i_reset = 1'b0;
        #1;
        exp_q.delete();
        prev_stall = 1'b0;
        check("post_rst_tready", 32'(s_axis_tready), 32'd1);
        check("post_rst_mvalid", 32'(m_axis_tvalid), 32'd0);
        check("post_rst_mdata", 32'(m_axis_tdata), 32'd0);
        check("post_rst_af", 32'(o_almost_full), 32'd0);
`ifdef AXIS_FIFO_LEVEL_EN
        check("post_rst_level", 32'(o_level), 32'd0);
`endif
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) begin
            step(1'b0, '0, 1'b1);
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        step(1'b0, '0, 1'b1);
        check("drain_idle_valid", 32'(m_axis_tvalid), 32'd0);
    endtask

    initial begin
        int p0;
        int q0;
        int first_v;
        int last_v;

        // ---- Reset state ----
        do_reset();

        // ---- Single beat: valid appears on the third sample after accept ----
        step(1'b1, 8'hA5, 1'b1);
        check("single_accept", 32'(push_cnt), 32'd1);
        step(1'b0, '0, 1'b1);
        check("single_lat1", 32'(m_axis_tvalid), 32'd0);
        step(1'b0, '0, 1'b1);
        check("single_lat2", 32'(m_axis_tvalid), 32'd0);
        step(1'b0, '0, 1'b1);
        check("single_valid", 32'(m_axis_tvalid), 32'd1);
        check("single_data", 32'(m_axis_tdata), 32'hA5);
        step(1'b0, '0, 1'b1);
        check("single_gone", 32'(m_axis_tvalid), 32'd0);

        // ---- Fill to capacity with the consumer stalled ----
        for (int i = 0; i <= CAP; i++) begin
            step(i < CAP, 8'(i), 1'b0);
            check("fill_tready", 32'(s_axis_tready), 32'(i < CAP));
            check("fill_af", 32'(o_almost_full), 32'(i >= 62));
`ifdef AXIS_FIFO_LEVEL_EN
            check("fill_level", 32'(o_level), 32'(i));
`endif
        end
        check("fill_count", 32'(exp_q.size()), 32'(CAP));
        drain(200);
        check("fill_last", 32'(last_pop), 32'h41);

        // ---- Streaming 1000 beats, both readies high ----
        p0 = push_cnt;
        q0 = pop_cnt;
        first_v = -1;
        last_v  = -1;
        for (int t = 0; t < 1200 && (pop_cnt - q0) < 1000; t++) begin
            step((push_cnt - p0) < 1000, 8'(push_cnt - p0), 1'b1);
            if (m_axis_tvalid) begin
                if (first_v < 0) first_v = t;
                last_v = t;
            end
        end
        check("stream_latency", 32'(first_v), 32'd3);
        check("stream_pops", 32'(pop_cnt - q0), 32'd1000);
        check("stream_no_bubble", 32'(last_v - first_v + 1), 32'd1000);
        drain(10);

        // ---- Random valid/ready with pointer wrap ----
        p0 = push_cnt;
        q0 = pop_cnt;
        for (int k = 0; k < 40000 && (push_cnt - p0) < 5000; k++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
        end
        check("rand_pushes", 32'(push_cnt - p0), 32'd5000);
        drain(300);
        check("rand_pops", 32'(pop_cnt - q0), 32'd5000);

        // ---- Reset with 10 beats held ----
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(8'h80 + i), 1'b0);
        end
        check("pre_rst_held", 32'(exp_q.size()), 32'd10);
        do_reset();
        q0 = pop_cnt;
        step(1'b1, 8'h3C, 1'b1);
        drain(20);
        check("rst_next_count", 32'(pop_cnt - q0), 32'd1);
        check("rst_next_beat", 32'(last_pop), 32'h3C);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
